// File: rtl/hslp_mul_pipe.sv
// Three-stage hybrid-segment approximate unsigned multiplier with a valid/ready stream on both sides.
// Optional build macro ERR_STAT_EN adds an aligned exact product (o_exact) and a saturating error counter (o_err_cnt).
module hslp_mul_pipe #(
  parameter int W         = 8,
  parameter int APX_TRUNC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [W-1:0]     i_a,
  input  logic [W-1:0]     i_b,
  input  logic             i_apx,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [2*W-1:0]   o_prod,
  output logic             o_apx
`ifdef ERR_STAT_EN
  ,
  output logic [2*W-1:0]   o_exact,
  output logic [15:0]      o_err_cnt
`endif
);

  localparam int SEG   = W / 4;
  localparam int NSP   = SEG * SEG;
  localparam int NTIER = 2 * SEG - 1;
  localparam int PW    = 2 * W;
  localparam logic [7:0] TRUNC_MASK = 8'(8'hFF << APX_TRUNC);

  // Sums sub-products per weight tier first, then combines the tiers.
  function automatic logic [PW-1:0] tier_sum(input logic [NSP-1:0][7:0] sp);
    logic [NTIER-1:0][PW-1:0] tier;
    logic [PW-1:0]            sum;
    tier = '0;
    sum  = '0;
    for (int i = 0; i < SEG; i++) begin
      for (int j = 0; j < SEG; j++) begin
        tier[i+j] = tier[i+j] + PW'(sp[i*SEG+j]);
      end
    end
    for (int t = 0; t < NTIER; t++) begin
      sum = sum + (tier[t] << (4 * t));
    end
    return sum;
  endfunction

  logic adv;

  logic [W-1:0]         a_q, a_d, b_q, b_d;
  logic                 apx1_q, apx1_d, v1_q, v1_d;

  logic [NSP-1:0][7:0]  sp_raw, sp_new;
  logic [NSP-1:0][7:0]  sp_q, sp_d;
  logic                 apx2_q, apx2_d, v2_q, v2_d;

  logic [PW-1:0]        prod_q, prod_d;
  logic                 apx3_q, apx3_d, v3_q, v3_d;

  assign adv     = ~v3_q | o_ready;
  assign i_ready = adv;
  assign o_valid = v3_q;
  assign o_prod  = prod_q;
  assign o_apx   = apx3_q;

  always_comb begin
    sp_raw = '0;
    sp_new = '0;
    for (int i = 0; i < SEG; i++) begin
      for (int j = 0; j < SEG; j++) begin
        sp_raw[i*SEG+j] = 8'(a_q[4*i +: 4]) * 8'(b_q[4*j +: 4]);
        // Only the low-weight tiers are truncated; higher tiers stay exact.
        if (apx1_q && ((i + j) < (SEG - 1))) begin
          sp_new[i*SEG+j] = sp_raw[i*SEG+j] & TRUNC_MASK;
        end else begin
          sp_new[i*SEG+j] = sp_raw[i*SEG+j];
        end
      end
    end
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    apx1_d = apx1_q;
    v1_d   = v1_q;
    sp_d   = sp_q;
    apx2_d = apx2_q;
    v2_d   = v2_q;
    prod_d = prod_q;
    apx3_d = apx3_q;
    v3_d   = v3_q;
    if (adv) begin
      a_d    = i_a;
      b_d    = i_b;
      apx1_d = i_apx;
      v1_d   = i_valid;
      sp_d   = sp_new;
      apx2_d = apx1_q;
      v2_d   = v1_q;
      prod_d = tier_sum(sp_q);
      apx3_d = apx2_q;
      v3_d   = v2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      apx1_q <= 1'b0;
      v1_q   <= 1'b0;
      sp_q   <= '0;
      apx2_q <= 1'b0;
      v2_q   <= 1'b0;
      prod_q <= '0;
      apx3_q <= 1'b0;
      v3_q   <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      apx1_q <= apx1_d;
      v1_q   <= v1_d;
      sp_q   <= sp_d;
      apx2_q <= apx2_d;
      v2_q   <= v2_d;
      prod_q <= prod_d;
      apx3_q <= apx3_d;
      v3_q   <= v3_d;
    end
  end

`ifdef ERR_STAT_EN
  logic [NSP-1:0][7:0]  spx_q, spx_d;
  logic [PW-1:0]        exact_q, exact_d;
  logic [15:0]          err_q, err_d;

  assign o_exact   = exact_q;
  assign o_err_cnt = err_q;

  always_comb begin
    spx_d   = spx_q;
    exact_d = exact_q;
    err_d   = err_q;
    if (adv) begin
      spx_d   = sp_raw;
      exact_d = tier_sum(spx_q);
    end
    if (v3_q && o_ready && (prod_q != exact_q) && (err_q != 16'hFFFF)) begin
      err_d = err_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spx_q   <= '0;
      exact_q <= '0;
      err_q   <= '0;
    end else begin
      spx_q   <= spx_d;
      exact_q <= exact_d;
      err_q   <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_hslp_mul_pipe.sv
// Self-checking bench for hslp_mul_pipe: W=8 vector table, backpressure, reset, and W=16 random stream.
module tb_hslp_mul_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        iv, ir, apx, ov, ordy, oapx;
  logic [7:0]  a, b;
  logic [15:0] prod;
  logic        iv16, ir16, apx16, ov16, ordy16, oapx16;
  logic [15:0] a16, b16;
  logic [31:0] prod16;
`ifdef ERR_STAT_EN
  logic [15:0] exact8, ecnt8, ecnt16;
  logic [31:0] exact16;
`endif

  hslp_mul_pipe #(.W(8), .APX_TRUNC(2)) u8 (
    .clk(clk), .rst_n(rst_n), .i_valid(iv), .i_ready(ir), .i_a(a), .i_b(b), .i_apx(apx),
    .o_valid(ov), .o_ready(ordy), .o_prod(prod), .o_apx(oapx)
`ifdef ERR_STAT_EN
    , .o_exact(exact8), .o_err_cnt(ecnt8)
`endif
  );

  hslp_mul_pipe #(.W(16), .APX_TRUNC(2)) u16 (
    .clk(clk), .rst_n(rst_n), .i_valid(iv16), .i_ready(ir16), .i_a(a16), .i_b(b16), .i_apx(apx16),
    .o_valid(ov16), .o_ready(ordy16), .o_prod(prod16), .o_apx(oapx16)
`ifdef ERR_STAT_EN
    , .o_exact(exact16), .o_err_cnt(ecnt16)
`endif
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        apx;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [15:0] prod;
    logic        apx;
    logic [15:0] exact;
  } exp8_t;

  vec_t        vt[12];
  exp8_t       q8[$];
  logic [32:0] q16[$];

  int          tests = 0;
  int          fails = 0;
  int          err_model = 0;
  logic        stall_prev = 1'b0;
  logic [15:0] held_prod;
  logic        held_apx;
  logic        last_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: nibble products, low two bits cleared in tiers i+j < seg-1 when approximating.
  function automatic logic [63:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic mapx, input int seg);
    logic [63:0] s;
    logic [7:0]  p;
    s = 64'd0;
    for (int i = 0; i < seg; i++) begin
      for (int j = 0; j < seg; j++) begin
        p = 8'(ma[4*i +: 4]) * 8'(mb[4*j +: 4]);
        if (mapx && ((i + j) < (seg - 1))) p[1:0] = 2'b00;
        s = s + (64'(p) << (4 * (i + j)));
      end
    end
    return s;
  endfunction

  // One W=8 cycle, entered and left at a falling edge.
  task automatic cyc8(input logic v, input logic [7:0] ta, input logic [7:0] tb,
                      input logic tapx, input logic tr, input logic [15:0] texp);
    exp8_t e;
    iv = v; a = ta; b = tb; apx = tapx; ordy = tr;
    #1;
    if (stall_prev) begin
      chk("hold_valid", ov, 1);
      chk("hold_prod", prod, held_prod);
      chk("hold_apx", oapx, held_apx);
    end
`ifdef ERR_STAT_EN
    chk("err_cnt", ecnt8, err_model);
`endif
    if (ov && !ordy) chk("stall_iready", ir, 0);
    if (ov && ordy) begin
      if (q8.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        e = q8.pop_front();
        chk("prod8", prod, e.prod);
        chk("apx8", oapx, e.apx);
`ifdef ERR_STAT_EN
        chk("exact8", exact8, e.exact);
`endif
        if (e.prod != e.exact && err_model != 65535) err_model++;
      end
    end
    last_acc = iv && ir;
    if (last_acc) begin
      e.prod  = texp;
      e.apx   = tapx;
      e.exact = 16'(ta) * 16'(tb);
      q8.push_back(e);
    end
    stall_prev = ov && !ordy;
    held_prod  = prod;
    held_apx   = oapx;
    @(negedge clk);
  endtask

  task automatic idle8(input int n);
    for (int k = 0; k < n; k++) cyc8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 16'h0000);
  endtask

  task automatic latency8(input logic [7:0] ta, input logic [7:0] tb, input logic tapx,
                          input logic [15:0] texp, input string name);
    int lat;
    cyc8(1'b1, ta, tb, tapx, 1'b1, texp);
    chk({name, "_accept"}, last_acc, 1);
    lat = 1;
    while (!ov && lat < 10) begin
      cyc8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 16'h0000);
      lat++;
    end
    chk(name, lat, 3);
    idle8(2);
  endtask

  initial begin
    vt[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    vt[1]  = '{8'hFF, 8'hFF, 1'b1, 16'hFE00};
    vt[2]  = '{8'h13, 8'h21, 1'b1, 16'h0270};
    vt[3]  = '{8'h13, 8'h21, 1'b0, 16'h0273};
    vt[4]  = '{8'h00, 8'h00, 1'b1, 16'h0000};
    vt[5]  = '{8'h0F, 8'h0F, 1'b1, 16'h00E0};
    vt[6]  = '{8'hF0, 8'h0F, 1'b1, 16'h0E10};
    vt[7]  = '{8'h37, 8'h5B, 1'b1, 16'h138C};
    vt[8]  = '{8'h37, 8'h5B, 1'b0, 16'h138D};
    vt[9]  = '{8'h01, 8'h03, 1'b1, 16'h0000};
    vt[10] = '{8'h80, 8'h02, 1'b1, 16'h0100};
    vt[11] = '{8'h0F, 8'hF0, 1'b1, 16'h0E10};

    rst_n = 1'b0;
    iv = 0; a = 0; b = 0; apx = 0; ordy = 1;
    iv16 = 0; a16 = 0; b16 = 0; apx16 = 0; ordy16 = 1;
    repeat (3) @(negedge clk);
    chk("rst_ovalid", ov, 0);
    chk("rst_prod", prod, 0);
    chk("rst_apx", oapx, 0);
    chk("rst_iready", ir, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // T1 latency on the exact full-scale product
    latency8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "t1_latency");

    // Back-to-back vector table
    for (int k = 0; k < 12; k++) cyc8(1'b1, vt[k].a, vt[k].b, vt[k].apx, 1'b1, vt[k].exp);
    idle8(5);
    chk("table_drained", q8.size(), 0);

    // T4 backpressure: five pairs, o_ready low for four cycles mid-stream
    begin
      int sent;
      logic [7:0] ta, tb;
      logic tapx;
      sent = 0;
      for (int c = 0; c < 40 && (sent < 5 || q8.size() != 0); c++) begin
        ta = 8'(17 * sent + 3);
        tb = 8'(29 * sent + 5);
        tapx = sent[0];
        cyc8(sent < 5, ta, tb, tapx, !(c >= 4 && c < 8), model(32'(ta), 32'(tb), tapx, 2)[15:0]);
        if (last_acc) sent++;
      end
      chk("t4_sent", sent, 5);
      chk("t4_drained", q8.size(), 0);
    end

    // T5 reset with three transactions in flight
    for (int k = 0; k < 3; k++) cyc8(1'b1, vt[k+5].a, vt[k+5].b, vt[k+5].apx, 1'b1, vt[k+5].exp);
    iv = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_ovalid", ov, 0);
    chk("t5_prod", prod, 0);
    chk("t5_apx", oapx, 0);
    q8.delete();
    err_model = 0;
    stall_prev = 1'b0;
    @(negedge clk);
`ifdef ERR_STAT_EN
    chk("t5_errcnt", ecnt8, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    latency8(8'h13, 8'h21, 1'b1, 16'h0270, "t5_latency");
    chk("t5_drained", q8.size(), 0);

    // T6 W=16 random stream
    begin
      int sent, rcv;
      logic [32:0] e;
      sent = 0;
      rcv = 0;
      for (int c = 0; c < 3000 && rcv < 1000; c++) begin
        iv16 = (sent < 1000);
        a16 = 16'($urandom);
        b16 = 16'($urandom);
        apx16 = 1'($urandom_range(0, 1));
        ordy16 = 1'b1;
        #1;
        if (ov16 && ordy16) begin
          if (q16.size() == 0) begin
            chk("w16_unexpected", 1, 0);
          end else begin
            e = q16.pop_front();
            chk("w16_prod", prod16, e[31:0]);
            chk("w16_apx", oapx16, e[32]);
            rcv++;
          end
        end
        if (iv16 && ir16) begin
          q16.push_back({apx16, model(32'(a16), 32'(b16), apx16, 4)[31:0]});
          sent++;
        end
        @(negedge clk);
      end
      iv16 = 1'b0;
      chk("w16_count", rcv, 1000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
